ts_submit_scheduler: RTL and testbench
======================================

TS_SUBMIT_SCHEDULER -- requirements
Module: ts_submit_scheduler

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 16: descriptor wait limit in clock cycles, legal range 2..255.
REQ-002 i_clk  in  1  clock; all logic on rising edge.
REQ-003 i_rst_n  in  1  reset, asynchronous, active-low.
REQ-004 i_sched_en  in  1  scheduler enable; 0 ignores slot switches.
REQ-005 iv_time_slot  in  10  current time slot; bits [4:0] index the schedule table.
REQ-006 i_time_slot_switch  in  1  one-cycle pulse marking the start of a new slot.
REQ-007 iv_tbl_wdata  in  6  table entry {valid[5], submit_addr[4:0]}.
REQ-008 iv_tbl_waddr  in  5  table write index.
REQ-009 i_tbl_wr  in  1  table write strobe.
REQ-010 ov_ts_submit_addr  out  5  TS flow submit address toward the submit-management block.
REQ-011 o_ts_submit_addr_wr  out  1  submit request, level, held until acknowledged.
REQ-012 i_ts_submit_addr_ack  in  1  submit request acknowledge.
REQ-013 iv_ts_descriptor  in  13  descriptor returned by the submit-management block.
REQ-014 i_ts_descriptor_wr  in  1  descriptor valid, level, held until acknowledged.
REQ-015 o_ts_descriptor_ack  out  1  descriptor acknowledge, one-cycle pulse.
REQ-016 ov_descriptor  out  13  descriptor forwarded downstream.
REQ-017 o_descriptor_wr  out  1  one-cycle downstream valid pulse.
REQ-018 ov_submit_cnt  out  16  count of descriptors successfully received.
REQ-019 ov_miss_cnt  out  16  count of submits that timed out.
REQ-020 o_slot_overrun_pulse  out  1  one-cycle pulse when a slot request is dropped.

Function
REQ-021 Table: 32 x 6 registers; i_tbl_wr writes iv_tbl_wdata at iv_tbl_waddr at the next edge; a write and a lookup of the same index in the same cycle reads the old value.
REQ-022 Trigger: i_time_slot_switch=1 with i_sched_en=1 and the entry at iv_time_slot[4:0] valid produces one request carrying that entry's submit_addr; an invalid entry produces no request.
REQ-023 Pending: the block keeps one pending request (flag plus 5-bit address); a trigger while the FSM is not IDLE sets pending if it is clear.
REQ-024 Overrun: a trigger while not IDLE with pending already set is dropped, pulses o_slot_overrun_pulse for the next cycle, and leaves the existing pending request unchanged.
REQ-025 FSM states: IDLE, REQ, WAIT_DESC, ACK.
REQ-026 IDLE: if pending is set, load its address and clear it; otherwise, on a trigger, load the trigger address. Either case sets o_ts_submit_addr_wr=1 on the next cycle and enters REQ. Pending has priority, and a simultaneous trigger becomes the new pending request.
REQ-027 REQ: hold o_ts_submit_addr_wr and ov_ts_submit_addr stable until i_ts_submit_addr_ack=1 is sampled, then drive wr=0 on the next cycle, clear the wait counter, and enter WAIT_DESC.
REQ-028 i_ts_submit_addr_ack is ignored in every state other than REQ.
REQ-029 WAIT_DESC, descriptor arrives: on i_ts_descriptor_wr=1, next cycle o_ts_descriptor_ack=1, ov_descriptor=iv_ts_descriptor, o_descriptor_wr=1, ov_submit_cnt increments, and the FSM enters ACK.
REQ-030 WAIT_DESC, no descriptor: the wait counter increments each cycle; when it reaches TIMEOUT_CYCLES-1 with no wr, ov_miss_cnt increments and the FSM returns to IDLE. A wr in that same cycle takes priority and counts as success.
REQ-031 ACK: o_ts_descriptor_ack and o_descriptor_wr return to 0, i_ts_descriptor_wr is ignored for this cycle (the responder is still dropping wr), and the FSM returns to IDLE.
REQ-032 Descriptor latency: ack and downstream pulse occur exactly one cycle after wr is first sampled high; each is exactly one cycle wide.
REQ-033 A descriptor wr outside WAIT_DESC is not acknowledged and not forwarded.
REQ-034 Counters saturate at 16'hFFFF.
REQ-035 ov_descriptor holds its last value between pulses.
REQ-036 Setting i_sched_en=0 mid-transaction does not abort it; the in-flight request and any pending request complete normally.

Reset
REQ-037 When i_rst_n=0, all outputs are 0, the FSM is IDLE, pending is clear, the wait counter is 0, and all table entries are 0 (invalid).
REQ-038 Reset asserted mid-transaction aborts it immediately; no counter updates for the aborted transaction.

Verification
REQ-039 Table[3]={1,5'd9}; slot switch with slot=3; responder acks after 1 cycle and returns descriptor 13'h0A5 four cycles later -> ov_ts_submit_addr=9, wr held until ack, o_ts_descriptor_ack and o_descriptor_wr each one cycle with ov_descriptor=13'h0A5, ov_submit_cnt=1.
REQ-040 Same setup, responder acks but never returns a descriptor -> return to IDLE TIMEOUT_CYCLES (16) cycles after entering WAIT_DESC, ov_miss_cnt=1, no o_descriptor_wr.
REQ-041 Table[4] invalid, slot switch with slot=4 -> no o_ts_submit_addr_wr, counters unchanged.
REQ-042 Three valid slot switches within a single transaction -> the second becomes pending and is issued next, the third causes exactly one o_slot_overrun_pulse, final ov_submit_cnt=2.
REQ-043 Descriptor wr held high for 2 cycles -> exactly one ack pulse and one forwarded descriptor.
REQ-044 Reset asserted during WAIT_DESC -> all outputs 0 and FSM IDLE on the next cycle; counters unchanged by the aborted transaction.

Source files
------------

// File: rtl/ts_submit_scheduler.sv
// ts_submit_scheduler
// Slot-driven TS flow submitter. A 32-entry schedule table maps each time slot
// to a submit address. On a slot switch, the block issues a submit request and
// waits for the returned descriptor, which it forwards downstream. It keeps one
// pending request to absorb a back-to-back slot. A waiting transaction gives up
// after TIMEOUT_CYCLES cycles without a descriptor.
module ts_submit_scheduler #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_sched_en,
  input  logic [9:0]  iv_time_slot,
  input  logic        i_time_slot_switch,
  input  logic [5:0]  iv_tbl_wdata,
  input  logic [4:0]  iv_tbl_waddr,
  input  logic        i_tbl_wr,
  output logic [4:0]  ov_ts_submit_addr,
  output logic        o_ts_submit_addr_wr,
  input  logic        i_ts_submit_addr_ack,
  input  logic [12:0] iv_ts_descriptor,
  input  logic        i_ts_descriptor_wr,
  output logic        o_ts_descriptor_ack,
  output logic [12:0] ov_descriptor,
  output logic        o_descriptor_wr,
  output logic [15:0] ov_submit_cnt,
  output logic [15:0] ov_miss_cnt,
  output logic        o_slot_overrun_pulse
);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_REQ       = 2'd1,
    S_WAIT_DESC = 2'd2,
    S_ACK       = 2'd3
  } state_t;

  // The wait counter compares against the last cycle of the timeout window.
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT_CYCLES - 1);

  // Saturating increment used by both statistics counters.
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : (v + 16'd1);
  endfunction

  state_t      state_q;
  logic [5:0]  tbl_q [32];
  logic        pend_q;
  logic [4:0]  pend_addr_q;
  logic [7:0]  wait_cnt_q;
  logic [4:0]  submit_addr_q;
  logic        submit_wr_q;
  logic        desc_ack_q;
  logic [12:0] desc_q;
  logic        desc_wr_q;
  logic [15:0] submit_cnt_q;
  logic [15:0] miss_cnt_q;
  logic        overrun_q;

  logic [5:0]  entry_s;
  logic        trig_s;
  logic        unused_slot_hi_s;

  // Only the low five slot bits select a table entry.
  assign unused_slot_hi_s = ^iv_time_slot[9:5];
  assign entry_s          = tbl_q[iv_time_slot[4:0]];
  assign trig_s           = i_time_slot_switch & i_sched_en & entry_s[5];

  assign ov_ts_submit_addr    = submit_addr_q;
  assign o_ts_submit_addr_wr  = submit_wr_q;
  assign o_ts_descriptor_ack  = desc_ack_q;
  assign ov_descriptor        = desc_q;
  assign o_descriptor_wr      = desc_wr_q;
  assign ov_submit_cnt        = submit_cnt_q;
  assign ov_miss_cnt          = miss_cnt_q;
  assign o_slot_overrun_pulse = overrun_q;

  // Schedule table. A lookup in the cycle of a write sees the previous entry.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < 32; i++) begin
        tbl_q[i] <= 6'd0;
      end
    end else if (i_tbl_wr) begin
      tbl_q[iv_tbl_waddr] <= iv_tbl_wdata;
    end
  end

  // Request/descriptor FSM with pending slot, timeout and statistics.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q       <= S_IDLE;
      pend_q        <= 1'b0;
      pend_addr_q   <= 5'd0;
      wait_cnt_q    <= 8'd0;
      submit_addr_q <= 5'd0;
      submit_wr_q   <= 1'b0;
      desc_ack_q    <= 1'b0;
      desc_q        <= 13'd0;
      desc_wr_q     <= 1'b0;
      submit_cnt_q  <= 16'd0;
      miss_cnt_q    <= 16'd0;
      overrun_q     <= 1'b0;
    end else begin
      // Pulse outputs drop by default and are raised only for one cycle.
      overrun_q  <= 1'b0;
      desc_ack_q <= 1'b0;
      desc_wr_q  <= 1'b0;

      // A slot arriving while busy is parked in the pending slot or, when
      // that slot is taken, dropped and reported.
      if ((state_q != S_IDLE) && trig_s) begin
        if (!pend_q) begin
          pend_q      <= 1'b1;
          pend_addr_q <= entry_s[4:0];
        end else begin
          overrun_q <= 1'b1;
        end
      end

      case (state_q)
        S_IDLE: begin
          if (pend_q) begin
            // The pending request goes first; a simultaneous slot replaces it.
            submit_addr_q <= pend_addr_q;
            submit_wr_q   <= 1'b1;
            state_q       <= S_REQ;
            pend_q        <= trig_s;
            if (trig_s) begin
              pend_addr_q <= entry_s[4:0];
            end
          end else if (trig_s) begin
            submit_addr_q <= entry_s[4:0];
            submit_wr_q   <= 1'b1;
            state_q       <= S_REQ;
          end
        end
        S_REQ: begin
          if (i_ts_submit_addr_ack) begin
            submit_wr_q <= 1'b0;
            wait_cnt_q  <= 8'd0;
            state_q     <= S_WAIT_DESC;
          end
        end
        S_WAIT_DESC: begin
          // A descriptor in the last window cycle still counts as a success.
          if (i_ts_descriptor_wr) begin
            desc_ack_q   <= 1'b1;
            desc_wr_q    <= 1'b1;
            desc_q       <= iv_ts_descriptor;
            submit_cnt_q <= sat_inc(submit_cnt_q);
            state_q      <= S_ACK;
          end else if (wait_cnt_q == WAIT_LAST) begin
            miss_cnt_q <= sat_inc(miss_cnt_q);
            state_q    <= S_IDLE;
          end else begin
            wait_cnt_q <= wait_cnt_q + 8'd1;
          end
        end
        S_ACK: begin
          // The responder is still lowering its wr here, so it is not looked at.
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ts_submit_scheduler.sv
// Directed bench for ts_submit_scheduler: a cycle table for the basic
// transaction and slot filtering, then hand sequences for the timeout, held
// wr, pending/overrun and reset corner cases.
module tb_ts_submit_scheduler;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sched_en;
  logic [9:0]  slot;
  logic        slot_sw;
  logic [5:0]  tbl_wdata;
  logic [4:0]  tbl_waddr;
  logic        tbl_wr;
  logic [4:0]  sub_addr;
  logic        sub_wr;
  logic        sub_ack;
  logic [12:0] ts_desc;
  logic        ts_desc_wr;
  logic        ts_desc_ack;
  logic [12:0] desc_out;
  logic        desc_out_wr;
  logic [15:0] submit_cnt;
  logic [15:0] miss_cnt;
  logic        overrun;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ts_submit_scheduler #(.TIMEOUT_CYCLES(TO)) dut (
    .i_clk(clk),
    .i_rst_n(rst_n),
    .i_sched_en(sched_en),
    .iv_time_slot(slot),
    .i_time_slot_switch(slot_sw),
    .iv_tbl_wdata(tbl_wdata),
    .iv_tbl_waddr(tbl_waddr),
    .i_tbl_wr(tbl_wr),
    .ov_ts_submit_addr(sub_addr),
    .o_ts_submit_addr_wr(sub_wr),
    .i_ts_submit_addr_ack(sub_ack),
    .iv_ts_descriptor(ts_desc),
    .i_ts_descriptor_wr(ts_desc_wr),
    .o_ts_descriptor_ack(ts_desc_ack),
    .ov_descriptor(desc_out),
    .o_descriptor_wr(desc_out_wr),
    .ov_submit_cnt(submit_cnt),
    .ov_miss_cnt(miss_cnt),
    .o_slot_overrun_pulse(overrun)
  );

  typedef struct {
    logic        sw;
    logic        en;
    logic [9:0]  sl;
    logic        tw;
    logic [4:0]  wa;
    logic [5:0]  wd;
    logic        ack;
    logic        dw;
    logic [12:0] din;
    logic [4:0]  e_addr;
    logic        e_awr;
    logic        e_dack;
    logic        e_dwr;
    logic [12:0] e_desc;
    logic [15:0] e_sub;
    logic [15:0] e_miss;
    logic        e_ovr;
  } vec_t;

  vec_t vecs [13];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [4:0] addr, input logic awr,
                         input logic dack, input logic dwr, input logic [12:0] desc,
                         input logic [15:0] sub, input logic [15:0] miss, input logic ovr);
    chk({tag, ".submit_addr"}, 32'(sub_addr), 32'(addr));
    chk({tag, ".submit_wr"}, 32'(sub_wr), 32'(awr));
    chk({tag, ".desc_ack"}, 32'(ts_desc_ack), 32'(dack));
    chk({tag, ".desc_wr"}, 32'(desc_out_wr), 32'(dwr));
    chk({tag, ".descriptor"}, 32'(desc_out), 32'(desc));
    chk({tag, ".submit_cnt"}, 32'(submit_cnt), 32'(sub));
    chk({tag, ".miss_cnt"}, 32'(miss_cnt), 32'(miss));
    chk({tag, ".overrun"}, 32'(overrun), 32'(ovr));
  endtask

  // Advance one clock; outputs are examined 1 ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic trigger(input logic [9:0] s);
    slot_sw = 1'b1;
    slot    = s;
    step();
    slot_sw = 1'b0;
  endtask

  task automatic pulse_ack();
    sub_ack = 1'b1;
    step();
    sub_ack = 1'b0;
  endtask

  initial begin
    // sw en slot tw wa wd ack dw din | addr awr dack dwr desc sub miss ovr
    vecs[0]  = '{1'b0, 1'b1, 10'd0,   1'b1, 5'd3, 6'h29, 1'b0, 1'b0, 13'd0,
                 5'd0, 1'b0, 1'b0, 1'b0, 13'd0, 16'd0, 16'd0, 1'b0};
    vecs[1]  = '{1'b1, 1'b1, 10'h3E3, 1'b0, 5'd0, 6'd0,  1'b0, 1'b0, 13'd0,
                 5'd9, 1'b1, 1'b0, 1'b0, 13'd0, 16'd0, 16'd0, 1'b0};
    vecs[2]  = '{1'b0, 1'b1, 10'd0,   1'b0, 5'd0, 6'd0,  1'b0, 1'b0, 13'd0,
                 5'd9, 1'b1, 1'b0, 1'b0, 13'd0, 16'd0, 16'd0, 1'b0};
    vecs[3]  = '{1'b0, 1'b1, 10'd0,   1'b0, 5'd0, 6'd0,  1'b1, 1'b0, 13'd0,
                 5'd9, 1'b0, 1'b0, 1'b0, 13'd0, 16'd0, 16'd0, 1'b0};
    vecs[4]  = '{1'b0, 1'b1, 10'd0,   1'b0, 5'd0, 6'd0,  1'b0, 1'b0, 13'd0,
                 5'd9, 1'b0, 1'b0, 1'b0, 13'd0, 16'd0, 16'd0, 1'b0};
    vecs[5]  = vecs[4];
    vecs[6]  = vecs[4];
    vecs[7]  = '{1'b0, 1'b1, 10'd0,   1'b0, 5'd0, 6'd0,  1'b0, 1'b1, 13'h0A5,
                 5'd9, 1'b0, 1'b1, 1'b1, 13'h0A5, 16'd1, 16'd0, 1'b0};
    vecs[8]  = '{1'b0, 1'b1, 10'd0,   1'b0, 5'd0, 6'd0,  1'b1, 1'b0, 13'd0,
                 5'd9, 1'b0, 1'b0, 1'b0, 13'h0A5, 16'd1, 16'd0, 1'b0};
    vecs[9]  = '{1'b1, 1'b1, 10'd4,   1'b0, 5'd0, 6'd0,  1'b0, 1'b0, 13'd0,
                 5'd9, 1'b0, 1'b0, 1'b0, 13'h0A5, 16'd1, 16'd0, 1'b0};
    vecs[10] = '{1'b1, 1'b0, 10'd3,   1'b0, 5'd0, 6'd0,  1'b0, 1'b0, 13'd0,
                 5'd9, 1'b0, 1'b0, 1'b0, 13'h0A5, 16'd1, 16'd0, 1'b0};
    vecs[11] = '{1'b1, 1'b1, 10'd6,   1'b1, 5'd6, 6'h2C, 1'b0, 1'b0, 13'd0,
                 5'd9, 1'b0, 1'b0, 1'b0, 13'h0A5, 16'd1, 16'd0, 1'b0};
    vecs[12] = '{1'b0, 1'b1, 10'd0,   1'b0, 5'd0, 6'd0,  1'b1, 1'b0, 13'd0,
                 5'd9, 1'b0, 1'b0, 1'b0, 13'h0A5, 16'd1, 16'd0, 1'b0};

    rst_n = 1'b0; sched_en = 1'b0; slot = 10'd0; slot_sw = 1'b0;
    tbl_wdata = 6'd0; tbl_waddr = 5'd0; tbl_wr = 1'b0;
    sub_ack = 1'b0; ts_desc = 13'd0; ts_desc_wr = 1'b0;
    step();
    step();
    chk_all("reset", 5'd0, 1'b0, 1'b0, 1'b0, 13'd0, 16'd0, 16'd0, 1'b0);
    rst_n = 1'b1;

    // Basic transaction, invalid slot, disabled scheduler, write/lookup race.
    for (int i = 0; i < 13; i++) begin
      slot_sw = vecs[i].sw; sched_en = vecs[i].en; slot = vecs[i].sl;
      tbl_wr = vecs[i].tw; tbl_waddr = vecs[i].wa; tbl_wdata = vecs[i].wd;
      sub_ack = vecs[i].ack; ts_desc_wr = vecs[i].dw; ts_desc = vecs[i].din;
      step();
      chk_all($sformatf("vec%0d", i), vecs[i].e_addr, vecs[i].e_awr, vecs[i].e_dack,
              vecs[i].e_dwr, vecs[i].e_desc, vecs[i].e_sub, vecs[i].e_miss, vecs[i].e_ovr);
    end
    slot_sw = 1'b0; tbl_wr = 1'b0; sub_ack = 1'b0; ts_desc_wr = 1'b0; sched_en = 1'b1;

    // Timeout: no descriptor; give up 16 cycles after entering WAIT_DESC.
    trigger(10'd3);
    chk("to.req_wr", 32'(sub_wr), 32'd1);
    pulse_ack();
    chk("to.req_drop", 32'(sub_wr), 32'd0);
    for (int k = 1; k < TO; k++) begin
      step();
      chk($sformatf("to.miss_c%0d", k), 32'(miss_cnt), 32'd0);
      chk($sformatf("to.dwr_c%0d", k), 32'(desc_out_wr), 32'd0);
    end
    step();
    chk_all("to.end", 5'd9, 1'b0, 1'b0, 1'b0, 13'h0A5, 16'd1, 16'd1, 1'b0);
    // A descriptor while idle is neither acknowledged nor forwarded.
    ts_desc_wr = 1'b1; ts_desc = 13'h1FFF;
    step();
    chk_all("idle_wr", 5'd9, 1'b0, 1'b0, 1'b0, 13'h0A5, 16'd1, 16'd1, 1'b0);
    ts_desc_wr = 1'b0;
    step();

    // A descriptor in the final window cycle wins over the timeout.
    trigger(10'd3);
    pulse_ack();
    for (int k = 1; k < TO; k++) begin
      step();
    end
    ts_desc_wr = 1'b1; ts_desc = 13'h1234;
    step();
    chk_all("edge.hit", 5'd9, 1'b0, 1'b1, 1'b1, 13'h1234, 16'd2, 16'd1, 1'b0);
    ts_desc_wr = 1'b0;
    step();
    chk_all("edge.after", 5'd9, 1'b0, 1'b0, 1'b0, 13'h1234, 16'd2, 16'd1, 1'b0);

    // Descriptor wr held for two cycles gives one ack and one forward.
    trigger(10'd6);
    chk("hold.addr", 32'(sub_addr), 32'd12);
    pulse_ack();
    step();
    ts_desc_wr = 1'b1; ts_desc = 13'h0F0;
    step();
    chk_all("hold.c1", 5'd12, 1'b0, 1'b1, 1'b1, 13'h0F0, 16'd3, 16'd1, 1'b0);
    step();
    chk_all("hold.c2", 5'd12, 1'b0, 1'b0, 1'b0, 13'h0F0, 16'd3, 16'd1, 1'b0);
    ts_desc_wr = 1'b0;
    step();
    chk_all("hold.c3", 5'd12, 1'b0, 1'b0, 1'b0, 13'h0F0, 16'd3, 16'd1, 1'b0);

    // Three slots in one transaction: pending, overrun, enable dropped.
    trigger(10'd3);
    chk_all("ovr.first", 5'd9, 1'b1, 1'b0, 1'b0, 13'h0F0, 16'd3, 16'd1, 1'b0);
    trigger(10'd6);
    chk_all("ovr.second", 5'd9, 1'b1, 1'b0, 1'b0, 13'h0F0, 16'd3, 16'd1, 1'b0);
    trigger(10'd3);
    chk_all("ovr.third", 5'd9, 1'b1, 1'b0, 1'b0, 13'h0F0, 16'd3, 16'd1, 1'b1);
    sched_en = 1'b0;
    step();
    chk("ovr.pulse_end", 32'(overrun), 32'd0);
    pulse_ack();
    chk("ovr.ack1", 32'(sub_wr), 32'd0);
    ts_desc_wr = 1'b1; ts_desc = 13'h111;
    step();
    chk_all("ovr.desc1", 5'd9, 1'b0, 1'b1, 1'b1, 13'h111, 16'd4, 16'd1, 1'b0);
    ts_desc_wr = 1'b0;
    step();
    step();
    chk_all("ovr.pend_issue", 5'd12, 1'b1, 1'b0, 1'b0, 13'h111, 16'd4, 16'd1, 1'b0);
    pulse_ack();
    ts_desc_wr = 1'b1; ts_desc = 13'h222;
    step();
    chk_all("ovr.desc2", 5'd12, 1'b0, 1'b1, 1'b1, 13'h222, 16'd5, 16'd1, 1'b0);
    ts_desc_wr = 1'b0;
    step();
    step();
    chk_all("ovr.done", 5'd12, 1'b0, 1'b0, 1'b0, 13'h222, 16'd5, 16'd1, 1'b0);

    // Reset during WAIT_DESC aborts at once; the table is cleared too.
    sched_en = 1'b1;
    trigger(10'd3);
    pulse_ack();
    step();
    rst_n = 1'b0;
    #1;
    chk_all("rst.async", 5'd0, 1'b0, 1'b0, 1'b0, 13'd0, 16'd0, 16'd0, 1'b0);
    ts_desc_wr = 1'b1; ts_desc = 13'h333;
    step();
    chk_all("rst.held", 5'd0, 1'b0, 1'b0, 1'b0, 13'd0, 16'd0, 16'd0, 1'b0);
    rst_n = 1'b1;
    step();
    chk_all("rst.idle_wr", 5'd0, 1'b0, 1'b0, 1'b0, 13'd0, 16'd0, 16'd0, 1'b0);
    ts_desc_wr = 1'b0;
    trigger(10'd3);
    chk_all("rst.tbl_clear", 5'd0, 1'b0, 1'b0, 1'b0, 13'd0, 16'd0, 16'd0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
